// File: rtl/cache_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter_if : I-cache / D-cache / memory-port bundle for the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cache_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  i_icache_start_read;
  logic [ADDR_WIDTH-1:0] i_icache_addr;
  logic                  o_icache_r_last;
  logic                  i_dcache_start_read;
  logic                  i_dcache_start_write;
  logic [ADDR_WIDTH-1:0] i_dcache_addr;
  logic                  o_dcache_r_last;
  logic                  o_dcache_b_resp;
  logic                  o_mem_start_read;
  logic                  o_mem_start_write;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  i_mem_r_last;
  logic                  i_mem_b_resp;
  logic [1:0]            o_owner;
  logic                  o_timeout;

  modport slave (
    input  i_icache_start_read, i_icache_addr,
    input  i_dcache_start_read, i_dcache_start_write, i_dcache_addr,
    input  i_mem_r_last, i_mem_b_resp,
    output o_icache_r_last, o_dcache_r_last, o_dcache_b_resp,
    output o_mem_start_read, o_mem_start_write, o_mem_addr,
    output o_owner, o_timeout
  );

  modport master (
    output i_icache_start_read, i_icache_addr,
    output i_dcache_start_read, i_dcache_start_write, i_dcache_addr,
    output i_mem_r_last, i_mem_b_resp,
    input  o_icache_r_last, o_dcache_r_last, o_dcache_b_resp,
    input  o_mem_start_read, o_mem_start_write, o_mem_addr,
    input  o_owner, o_timeout
  );
endinterface

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter : shares one memory port between I-cache and D-cache miss
// FSMs, with watchdog. Optional macro CACHE_ARB_ROUND_ROBIN_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cache_mem_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  wire logic           clk,
  input  wire logic           arst,
  cache_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_I_RD = 2'd1,
    GNT_D_RD = 2'd2,
    GNT_D_WR = 2'd3
  } state_t;

  localparam int c_TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [c_TW-1:0] r_timer;
  logic            w_req_held;
  logic            w_done;
  logic            w_expire;
  logic            w_pick_d;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_req_held = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      GNT_I_RD: begin w_req_held = bus.i_icache_start_read;  w_done = bus.i_mem_r_last; end
      GNT_D_RD: begin w_req_held = bus.i_dcache_start_read;  w_done = bus.i_mem_r_last; end
      GNT_D_WR: begin w_req_held = bus.i_dcache_start_write; w_done = bus.i_mem_b_resp; end
      default:  ;
    endcase
  end

  // Timer is zero throughout IDLE, so every grant starts counting from 0.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                      r_timer <= '0;
    else if (r_state == IDLE)      r_timer <= '0;
    else if (r_timer != {c_TW{1'b1}}) r_timer <= r_timer + 1'b1;
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      assign w_expire = (r_state != IDLE) && w_req_held && !w_done &&
                        (r_timer >= c_TW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wdog
      assign w_expire = 1'b0;
    end
  endgenerate

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic r_rr_d;
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                                              r_rr_d <= 1'b1;
    else if (r_state == GNT_D_RD && bus.i_mem_r_last)      r_rr_d <= 1'b0;
    else if (r_state == GNT_I_RD && bus.i_mem_r_last)      r_rr_d <= 1'b1;
  end
  assign w_pick_d = r_rr_d;
`else
  assign w_pick_d = 1'b1;
`endif

  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) begin
      if (bus.i_dcache_start_write)
        w_next = GNT_D_WR;
      else if (bus.i_dcache_start_read && bus.i_icache_start_read)
        w_next = w_pick_d ? GNT_D_RD : GNT_I_RD;
      else if (bus.i_dcache_start_read)
        w_next = GNT_D_RD;
      else if (bus.i_icache_start_read)
        w_next = GNT_I_RD;
    end else if (!w_req_held || w_done || w_expire) begin
      w_next = IDLE;
    end
  end

  always_comb begin
    bus.o_mem_addr = '0;
    case (r_state)
      GNT_I_RD:           bus.o_mem_addr = bus.i_icache_addr;
      GNT_D_RD, GNT_D_WR: bus.o_mem_addr = bus.i_dcache_addr;
      default:            ;
    endcase
  end

  assign bus.o_mem_start_read  = ((r_state == GNT_I_RD) && bus.i_icache_start_read) ||
                                 ((r_state == GNT_D_RD) && bus.i_dcache_start_read);
  assign bus.o_mem_start_write = (r_state == GNT_D_WR) && bus.i_dcache_start_write;
  assign bus.o_icache_r_last   = (r_state == GNT_I_RD) && bus.i_mem_r_last && !w_expire;
  assign bus.o_dcache_r_last   = (r_state == GNT_D_RD) && bus.i_mem_r_last && !w_expire;
  assign bus.o_dcache_b_resp   = (r_state == GNT_D_WR) && bus.i_mem_b_resp && !w_expire;
  assign bus.o_owner           = r_state;
  assign bus.o_timeout         = w_expire;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter : directed self-checking bench for cache_mem_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cache_mem_arbiter;

  logic clk = 1'b0;
  logic arst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_WIDTH(64)) bus ();

  cache_mem_arbiter #(
    .ADDR_WIDTH     (64),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [1:0] exp_owner [4];

  initial begin
    arst                     = 1'b1;
    bus.i_icache_start_read  = 1'b0;
    bus.i_icache_addr        = '0;
    bus.i_dcache_start_read  = 1'b0;
    bus.i_dcache_start_write = 1'b0;
    bus.i_dcache_addr        = '0;
    bus.i_mem_r_last         = 1'b0;
    bus.i_mem_b_resp         = 1'b0;
    tick();
    tick();
    chk("rst_owner", bus.o_owner, 0);
    chk("rst_rd", bus.o_mem_start_read, 0);
    chk("rst_wr", bus.o_mem_start_write, 0);
    chk("rst_addr", bus.o_mem_addr, 0);
    chk("rst_to", bus.o_timeout, 0);
    arst = 1'b0;

    // Reset in the middle of a D read grant
    tick();
    bus.i_dcache_start_read = 1'b1;
    bus.i_dcache_addr       = 64'h2040;
    settle();
    chk("rm_idle", bus.o_owner, 0);
    tick();
    chk("rm_gnt", bus.o_owner, 2);
    chk("rm_rd", bus.o_mem_start_read, 1);
    chk("rm_addr", bus.o_mem_addr, 64'h2040);
    tick();
    arst = 1'b1;
    settle();
    chk("rm_async_owner", bus.o_owner, 0);
    chk("rm_async_rd", bus.o_mem_start_read, 0);
    chk("rm_async_addr", bus.o_mem_addr, 0);
    tick();
    arst = 1'b0;
    settle();
    chk("rm_rel_owner", bus.o_owner, 0);
    tick();
    chk("rm_regnt", bus.o_owner, 2);
    bus.i_dcache_start_read = 1'b0;
    tick();
    chk("rm_drop", bus.o_owner, 0);

    // Simultaneous I and D reads: D wins, I follows after one IDLE cycle
    bus.i_icache_start_read = 1'b1;
    bus.i_icache_addr       = 64'h1000;
    bus.i_dcache_start_read = 1'b1;
    bus.i_dcache_addr       = 64'h2040;
    tick();
    chk("sim_owner_d", bus.o_owner, 2);
    chk("sim_addr_d", bus.o_mem_addr, 64'h2040);
    tick();
    tick();
    tick();
    chk("sim_hold_d", bus.o_owner, 2);
    tick();
    bus.i_mem_r_last = 1'b1;
    settle();
    chk("sim_dlast", bus.o_dcache_r_last, 1);
    chk("sim_ilast_masked", bus.o_icache_r_last, 0);
    chk("sim_to", bus.o_timeout, 0);
    tick();
    bus.i_mem_r_last        = 1'b0;
    bus.i_dcache_start_read = 1'b0;
    settle();
    chk("sim_gap", bus.o_owner, 0);
    chk("sim_gap_addr", bus.o_mem_addr, 0);
    tick();
    chk("sim_owner_i", bus.o_owner, 1);
    chk("sim_addr_i", bus.o_mem_addr, 64'h1000);
    chk("sim_rd_i", bus.o_mem_start_read, 1);
    bus.i_mem_r_last = 1'b1;
    settle();
    chk("sim_ilast", bus.o_icache_r_last, 1);
    chk("sim_dlast_masked", bus.o_dcache_r_last, 0);
    tick();
    bus.i_mem_r_last        = 1'b0;
    bus.i_icache_start_read = 1'b0;
    settle();
    chk("sim_end", bus.o_owner, 0);

    // D write-back then D fill
    bus.i_dcache_start_write = 1'b1;
    bus.i_dcache_addr        = 64'h3000;
    tick();
    chk("wb_owner", bus.o_owner, 3);
    chk("wb_wr", bus.o_mem_start_write, 1);
    chk("wb_rd", bus.o_mem_start_read, 0);
    chk("wb_addr", bus.o_mem_addr, 64'h3000);
    tick();
    tick();
    bus.i_mem_r_last = 1'b1;
    settle();
    chk("wb_rlast_ignored", bus.o_dcache_r_last, 0);
    tick();
    chk("wb_stay", bus.o_owner, 3);
    bus.i_mem_r_last = 1'b0;
    bus.i_mem_b_resp = 1'b1;
    settle();
    chk("wb_bresp", bus.o_dcache_b_resp, 1);
    tick();
    bus.i_mem_b_resp         = 1'b0;
    bus.i_dcache_start_write = 1'b0;
    bus.i_dcache_start_read  = 1'b1;
    bus.i_dcache_addr        = 64'h3040;
    settle();
    chk("wb_idle", bus.o_owner, 0);
    tick();
    chk("wb_fill", bus.o_owner, 2);
    chk("wb_fill_addr", bus.o_mem_addr, 64'h3040);
    bus.i_mem_r_last = 1'b1;
    tick();
    bus.i_mem_r_last        = 1'b0;
    bus.i_dcache_start_read = 1'b0;

    // Both D requests: write wins
    bus.i_dcache_start_write = 1'b1;
    bus.i_dcache_start_read  = 1'b1;
    tick();
    chk("dd_owner", bus.o_owner, 3);
    chk("dd_rd_off", bus.o_mem_start_read, 0);
    bus.i_mem_b_resp = 1'b1;
    tick();
    bus.i_mem_b_resp         = 1'b0;
    bus.i_dcache_start_write = 1'b0;
    tick();
    chk("dd_read_after", bus.o_owner, 2);
    bus.i_dcache_start_read = 1'b0;
    tick();

    // Watchdog with TIMEOUT_CYCLES = 8
    bus.i_icache_start_read = 1'b1;
    bus.i_icache_addr       = 64'h1000;
    tick();
    chk("wd_gnt", bus.o_owner, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("wd_early", bus.o_timeout, 0);
    tick();
    chk("wd_fire", bus.o_timeout, 1);
    chk("wd_no_last", bus.o_icache_r_last, 0);
    tick();
    chk("wd_idle", bus.o_owner, 0);
    chk("wd_pulse", bus.o_timeout, 0);
    tick();
    chk("wd_regnt", bus.o_owner, 1);
    for (int i = 0; i < 7; i++) tick();
    bus.i_mem_r_last = 1'b1;
    settle();
    chk("wd_race_to", bus.o_timeout, 0);
    chk("wd_race_last", bus.o_icache_r_last, 1);
    tick();
    bus.i_mem_r_last        = 1'b0;
    bus.i_icache_start_read = 1'b0;
    settle();
    chk("wd_done", bus.o_owner, 0);

    // Abort: D read dropped after three grant cycles
    bus.i_dcache_start_read = 1'b1;
    bus.i_dcache_addr       = 64'h2080;
    tick();
    chk("ab_gnt", bus.o_owner, 2);
    tick();
    tick();
    bus.i_dcache_start_read = 1'b0;
    settle();
    chk("ab_rd_off", bus.o_mem_start_read, 0);
    chk("ab_to", bus.o_timeout, 0);
    tick();
    chk("ab_idle", bus.o_owner, 0);
    bus.i_mem_r_last = 1'b1;
    settle();
    chk("ab_late_d", bus.o_dcache_r_last, 0);
    chk("ab_late_i", bus.o_icache_r_last, 0);
    chk("ab_late_to", bus.o_timeout, 0);
    tick();
    bus.i_mem_r_last = 1'b0;
    settle();
    chk("ab_stay", bus.o_owner, 0);

    // Both reads held through four completed grants
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    exp_owner[0] = 2'd2; exp_owner[1] = 2'd1; exp_owner[2] = 2'd2; exp_owner[3] = 2'd1;
`else
    exp_owner[0] = 2'd2; exp_owner[1] = 2'd2; exp_owner[2] = 2'd2; exp_owner[3] = 2'd2;
`endif
    bus.i_icache_start_read = 1'b1;
    bus.i_dcache_start_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr_owner%0d", k), bus.o_owner, exp_owner[k]);
      bus.i_mem_r_last = 1'b1;
      tick();
      bus.i_mem_r_last = 1'b0;
      settle();
      chk($sformatf("rr_gap%0d", k), bus.o_owner, 0);
    end
    bus.i_icache_start_read = 1'b0;
    bus.i_dcache_start_read = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single external memory port between the instruction-cache and data-cache miss FSMs.
- Each cache FSM holds a level request (start_read during ALLOCATE, start_write during WRITE_BACK) until it sees r_last or b_resp.
- The arbiter grants one owner at a time and routes that owner's address and start strobe to memory. It returns r_last/b_resp to the owner only.
- A watchdog frees the port if memory never completes a transaction.

Parameters:
- ADDR_WIDTH, 64, width of the block-aligned addresses.
- TIMEOUT_CYCLES, 256, cycles a grant may stay open without completion; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- i_icache_start_read  in  1  I-cache block-fill request (level).
- i_icache_addr  in  ADDR_WIDTH  I-cache fill address.
- o_icache_r_last  out  1  final read beat, I-cache grant only.
- i_dcache_start_read  in  1  D-cache block-fill request (level).
- i_dcache_start_write  in  1  D-cache write-back request (level).
- i_dcache_addr  in  ADDR_WIDTH  D-cache address (fill or victim).
- o_dcache_r_last  out  1  final read beat, D-cache read grant only.
- o_dcache_b_resp  out  1  write response, D-cache write grant only.
- o_mem_start_read  out  1  read start to the memory/AXI master.
- o_mem_start_write  out  1  write start to the memory/AXI master.
- o_mem_addr  out  ADDR_WIDTH  owner's address; 0 when IDLE.
- i_mem_r_last  in  1  last read beat from memory.
- i_mem_b_resp  in  1  write response from memory.
- o_owner  out  2  0 = none, 1 = I-read, 2 = D-read, 3 = D-write.
- o_timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- States: IDLE, GNT_I_RD, GNT_D_RD, GNT_D_WR. o_owner encodes the state directly (IDLE = 0, GNT_I_RD = 1, GNT_D_RD = 2, GNT_D_WR = 3).
- Reset, whenever arst is high (including mid-transaction):
  - state = IDLE, timer = 0, round-robin pointer = D.
  - All outputs are 0 immediately, asynchronously.
- IDLE → grant on the next clock edge when any request is high. Fixed priority: D write > D read > I read.
- Latency: request high at edge t, grant state from t+1. The mem start strobe and address are driven combinationally in the grant state.
  - o_mem_start_read = (GNT_I_RD & i_icache_start_read) | (GNT_D_RD & i_dcache_start_read).
  - o_mem_start_write = GNT_D_WR & i_dcache_start_write.
  - o_mem_addr = owner's address; 0 in IDLE.
- Completion routing is combinational and owner-only:
  - o_icache_r_last = GNT_I_RD & i_mem_r_last.
  - o_dcache_r_last = GNT_D_RD & i_mem_r_last.
  - o_dcache_b_resp = GNT_D_WR & i_mem_b_resp.
  - Completion inputs seen in IDLE or in a mismatched grant (e.g. b_resp in a read grant) are ignored.
- Grant → IDLE on the edge after completion: r_last for read grants, b_resp for the write grant.
  - Back-to-back grants therefore have one IDLE cycle between them.
  - The requester's request is still high in its completion cycle, which is correct; the arbiter re-samples requests only in IDLE.
- Requester drops its request mid-grant (abort) → IDLE next edge. No completion is forwarded and no timeout is raised.
- D write-back followed by D fill: b_resp at t, IDLE at t+1. D read is granted at t+2 unless pre-empted by a higher-priority request.
- Both D requests high at once (protocol error): write wins.
- Watchdog timer:
  - Width clog2(TIMEOUT_CYCLES+1).
  - Cleared on grant entry; increments each grant cycle without completion.
  - At TIMEOUT_CYCLES-1 without completion: o_timeout = 1 for that cycle, completions to the owner are suppressed, IDLE next edge.
  - Completion in the same cycle as expiry: completion wins and o_timeout stays 0.
  - Timer saturates; it never wraps.
- A pending request is never lost. A non-granted request stays level and is re-evaluated in the next IDLE cycle.

Optional Feature:
- Macro CACHE_ARB_ROUND_ROBIN_EN.
- When defined:
  - Round-robin between D read and I read when both are requested in IDLE.
  - The pointer flips to the other side after each completed read grant; timeout and abort do not flip it.
  - Pointer resets to D.
  - D write still has absolute priority.
- When undefined: fixed priority D write > D read > I read, and no pointer register exists.

Test Plan:
- Reset mid-grant: D read granted, arst asserted 1 cycle → all outputs 0 that cycle, o_owner = 0 after release, D request re-granted 1 cycle later.
- Simultaneous I read (addr 0x1000) and D read (addr 0x2040) at t:
  - o_owner = 2 and o_mem_addr = 0x2040 at t+1.
  - i_mem_r_last at t+5 → o_dcache_r_last = 1, o_icache_r_last = 0.
  - o_owner = 1 and o_mem_addr = 0x1000 at t+7.
- D write-back then fill: start_write at t, b_resp at t+4 → o_dcache_b_resp = 1 at t+4; D fill granted (o_owner = 2) at t+6.
- Watchdog, TIMEOUT_CYCLES = 8: I read granted at t+1, no r_last → o_timeout = 1 at t+8, o_icache_r_last = 0, o_owner = 0 at t+9. Repeat with r_last at t+8 → o_timeout = 0, r_last forwarded.
- Abort: D read granted, request dropped after 3 cycles → IDLE next edge, o_timeout stays 0, a late i_mem_r_last in IDLE is not forwarded.
- CACHE_ARB_ROUND_ROBIN_EN defined, both read requests held continuously → owners alternate 2, 1, 2, 1 across four completed reads.
